// File: rtl/final_layer_pkg.sv
// Shared types and the parameter-driven region map for the final classifier
// weight store.
package final_layer_pkg;

    typedef enum logic [3:0] {
        CONV_W    = 4'd0,
        BN1_GAMMA = 4'd1,
        BN1_BETA  = 4'd2,
        L1_W      = 4'd3,
        L1_BIAS   = 4'd4,
        BN2_GAMMA = 4'd5,
        BN2_BETA  = 4'd6,
        L2_W      = 4'd7,
        L2_BIAS   = 4'd8
    } weight_type_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } state_e;

    typedef struct packed {
        int unsigned base;
        int unsigned size;
    } region_t;

    function automatic int unsigned depth_of(input int unsigned in_ch, input int unsigned mid_ch,
                                             input int unsigned lin, input int unsigned lmid,
                                             input int unsigned nc);
        return in_ch * mid_ch + mid_ch * 2 + lmid * lin + lmid * 3 + nc * lmid + nc;
    endfunction

    // Regions are packed back to back in weight_type order; illegal types get size 0.
    function automatic region_t region_of(input logic [3:0] typ, input int unsigned in_ch,
                                          input int unsigned mid_ch, input int unsigned lin,
                                          input int unsigned lmid, input int unsigned nc);
        int unsigned sizes [9];
        int unsigned base;
        region_t     r;
        sizes = '{in_ch * mid_ch, mid_ch, mid_ch, lmid * lin, lmid, lmid, lmid, nc * lmid, nc};
        r     = '{base: 0, size: 0};
        base  = 0;
        for (int i = 0; i <= int'(L2_BIAS); i++) begin
            if (typ == 4'(i)) r = '{base: base, size: sizes[i]};
            base += sizes[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/final_layer_weight_server_if.sv
// Load stream and weight request/response bundle between the host/final layer
// (master) and the weight server (slave).
interface final_layer_weight_server_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 12
);
    logic              load_start;
    logic              load_valid;
    logic [WIDTH-1:0]  load_data;
    logic              load_ready;
    logic              load_done;
    logic              weight_req;
    logic [ADDR_W-1:0] weight_addr;
    logic [3:0]        weight_type;
    logic [WIDTH-1:0]  weight_data;
    logic              weight_valid;
    logic              weight_err;

    modport master (
        output load_start, load_valid, load_data, weight_req, weight_addr, weight_type,
        input  load_ready, load_done, weight_data, weight_valid, weight_err
    );

    modport slave (
        input  load_start, load_valid, load_data, weight_req, weight_addr, weight_type,
        output load_ready, load_done, weight_data, weight_valid, weight_err
    );
endinterface

// File: rtl/final_layer_weight_ram.sv
// Single-port synchronous weight RAM, one write enable, registered read.
module final_layer_weight_ram #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 3791,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset; contents survive rst and are only defined once loaded.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end
endmodule

// File: rtl/final_layer_weight_server.sv
// Weight store for the final classifier stage: a sequential host load fills one
// RAM, then region-checked reads are answered one cycle after each request.
module final_layer_weight_server
    import final_layer_pkg::*;
#(
    parameter int WIDTH               = 16,
    parameter int IN_CHANNELS         = 16,
    parameter int MID_CHANNELS        = 32,
    parameter int LINEAR_FEATURES_IN  = 32,
    parameter int LINEAR_FEATURES_MID = 64,
    parameter int NUM_CLASSES         = 15,
    parameter int DEPTH  = int'(depth_of(IN_CHANNELS, MID_CHANNELS, LINEAR_FEATURES_IN,
                                         LINEAR_FEATURES_MID, NUM_CLASSES)),
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    final_layer_weight_server_if.slave bus
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e            state;
    state_e            state_nx;
    logic [ADDR_W-1:0] ptr;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [WIDTH-1:0]  ram_rdata;
    region_t           region;
    logic              req_ok;
    logic              resp_ok;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nx = state;
        if (bus.load_start)
            state_nx = ST_LOAD;
        else if (state == ST_LOAD && bus.load_valid && ptr == LAST_ADDR)
            state_nx = ST_READY;
    end

    // A restart in the same cycle as a load word drops that word.
    assign ram_we   = !rst && state == ST_LOAD && bus.load_valid && !bus.load_start;
    assign ram_addr = (state == ST_LOAD) ? ptr : bus.weight_addr;

    always_comb begin
        region = region_of(bus.weight_type, IN_CHANNELS, MID_CHANNELS, LINEAR_FEATURES_IN,
                           LINEAR_FEATURES_MID, NUM_CLASSES);
        req_ok = state == ST_READY
              && 32'(bus.weight_addr) >= region.base
              && 32'(bus.weight_addr) <  region.base + region.size;
    end

    final_layer_weight_ram #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (bus.load_data),
        .rdata (ram_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_EMPTY;
            ptr              <= '0;
            bus.load_ready   <= 1'b0;
            bus.load_done    <= 1'b0;
            bus.weight_valid <= 1'b0;
            bus.weight_err   <= 1'b0;
            resp_ok          <= 1'b0;
        end else begin
            state <= state_nx;
            if (bus.load_start)
                ptr <= '0;
            else if (ram_we)
                ptr <= ptr + ADDR_W'(1);
            bus.load_ready   <= state_nx == ST_LOAD;
            bus.load_done    <= state_nx == ST_READY;
            bus.weight_valid <= bus.weight_req;
            resp_ok          <= bus.weight_req && req_ok;
            // A failing request outranks a restart in the same cycle.
            if (bus.weight_req && !req_ok)
                bus.weight_err <= 1'b1;
            else if (bus.load_start)
                bus.weight_err <= 1'b0;
        end
    end

    assign bus.weight_data = resp_ok ? ram_rdata : '0;
endmodule

// File: tb/tb_final_layer_weight_server.sv
// Scoreboard bench for final_layer_weight_server: inputs change and outputs are
// sampled on the falling edge; expected responses queue up as requests are driven.
module tb_final_layer_weight_server;
    localparam int WIDTH  = 16;
    localparam int DEPTH  = 3791;
    localparam int ADDR_W = 12;
    localparam logic [WIDTH-1:0] KEY1 = 16'h5A00;
    localparam logic [WIDTH-1:0] KEY2 = 16'hA500;
    localparam logic [WIDTH-1:0] KEY3 = 16'h3C00;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb [$];

    final_layer_weight_server_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    final_layer_weight_server #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic drive_req(input int addr, input int typ, input logic [WIDTH-1:0] d,
                             input logic e_err);
        bus.weight_req  = 1'b1;
        bus.weight_addr = ADDR_W'(addr);
        bus.weight_type = 4'(typ);
        sb.push_back(exp_t'{data: d, err: e_err});
    endtask

    task automatic load_words(input int first, input int n, input logic [WIDTH-1:0] key);
        for (int i = first; i < first + n; i++) begin
            if (i % 7 == 3) begin
                bus.load_valid = 1'b0;
                @(negedge clk);
            end
            bus.load_valid = 1'b1;
            bus.load_data  = WIDTH'(i) ^ key;
            @(negedge clk);
        end
        bus.load_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (bus.weight_valid !== 1'b0 || bus.weight_data !== '0 || bus.weight_err !== 1'b0
            || bus.load_ready !== 1'b0 || bus.load_done !== 1'b0) begin
            errors++;
            $display("FAIL reset: valid=%b data=%h err=%b ready=%b done=%b, want all 0",
                     bus.weight_valid, bus.weight_data, bus.weight_err, bus.load_ready, bus.load_done);
        end
        rst = 1'b0;
    endtask

    task automatic test_empty_read();
        exp_t e;
        drive_req(512, 1, '0, 1'b1);
        @(negedge clk);
        bus.weight_req = 1'b0;
        e = sb.pop_front();
        checks++;
        if (bus.weight_valid !== 1'b1 || bus.weight_data !== e.data || bus.weight_err !== e.err) begin
            errors++;
            $display("FAIL empty_read: valid=%b data=%h err=%b, want valid=1 data=%h err=%b",
                     bus.weight_valid, bus.weight_data, bus.weight_err, e.data, e.err);
        end
    endtask

    task automatic test_first_load();
        bus.load_start = 1'b1;
        @(negedge clk);
        bus.load_start = 1'b0;
        checks++;
        if (bus.load_ready !== 1'b1 || bus.load_done !== 1'b0 || bus.weight_err !== 1'b0) begin
            errors++;
            $display("FAIL load_start: ready=%b done=%b err=%b, want ready=1 done=0 err=0",
                     bus.load_ready, bus.load_done, bus.weight_err);
        end
        load_words(0, DEPTH - 1, KEY1);
        checks++;
        if (bus.load_done !== 1'b0 || bus.load_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_one_short: done=%b ready=%b, want done=0 ready=1",
                     bus.load_done, bus.load_ready);
        end
        load_words(DEPTH - 1, 1, KEY1);
        checks++;
        if (bus.load_done !== 1'b1 || bus.load_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_done: done=%b ready=%b, want done=1 ready=0",
                     bus.load_done, bus.load_ready);
        end
    endtask

    // load_valid is held high with junk throughout; READY must ignore it.
    task automatic test_region_read();
        int   addrs [7] = '{512, 512, 0, 511, 543, 2623, 3790};
        int   types [7] = '{1, 1, 0, 0, 1, 3, 8};
        exp_t e;
        bus.load_valid = 1'b1;
        bus.load_data  = 16'hDEAD;
        for (int i = 0; i < 7; i++) begin
            drive_req(addrs[i], types[i], WIDTH'(addrs[i]) ^ KEY1, 1'b0);
            @(negedge clk);
            bus.weight_req = 1'b0;
            e = sb.pop_front();
            checks++;
            if (bus.weight_valid !== 1'b1 || bus.weight_data !== e.data || bus.weight_err !== e.err) begin
                errors++;
                $display("FAIL region_read[%0d]: valid=%b data=%h err=%b, want valid=1 data=%h err=%b",
                         i, bus.weight_valid, bus.weight_data, bus.weight_err, e.data, e.err);
            end
            @(negedge clk);
            checks++;
            if (bus.weight_valid !== 1'b0) begin
                errors++;
                $display("FAIL valid_drop[%0d]: valid=%b, want 0", i, bus.weight_valid);
            end
        end
        bus.load_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            drive_req(576 + i, 3, WIDTH'(576 + i) ^ KEY1, 1'b0);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (bus.weight_valid !== 1'b1 || bus.weight_data !== e.data || bus.weight_err !== e.err) begin
                errors++;
                $display("FAIL back_to_back[%0d]: valid=%b data=%h err=%b, want valid=1 data=%h err=%b",
                         i, bus.weight_valid, bus.weight_data, bus.weight_err, e.data, e.err);
            end
        end
        bus.weight_req = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.weight_valid !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_end: valid=%b, want 0", bus.weight_valid);
        end
    endtask

    // Once err is set it stays set, so a later legal read still reports err=1.
    task automatic test_errors();
        int   addrs [5] = '{100, 512, 3000, 3800, 544};
        int   types [5] = '{4, 1, 12, 8, 1};
        int   datas [5] = '{0, 16'h5800, 0, 0, 0};
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            drive_req(addrs[i], types[i], WIDTH'(datas[i]), 1'b1);
            @(negedge clk);
            bus.weight_req = 1'b0;
            e = sb.pop_front();
            checks++;
            if (bus.weight_valid !== 1'b1 || bus.weight_data !== e.data || bus.weight_err !== e.err) begin
                errors++;
                $display("FAIL error_read[%0d]: valid=%b data=%h err=%b, want valid=1 data=%h err=%b",
                         i, bus.weight_valid, bus.weight_data, bus.weight_err, e.data, e.err);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_restart();
        exp_t e;
        // Restart from READY with a request in the same cycle: still served from READY.
        bus.load_start = 1'b1;
        drive_req(2816, 7, WIDTH'(2816) ^ KEY1, 1'b0);
        @(negedge clk);
        bus.load_start = 1'b0;
        bus.weight_req = 1'b0;
        e = sb.pop_front();
        checks++;
        if (bus.weight_valid !== 1'b1 || bus.weight_data !== e.data || bus.weight_err !== e.err
            || bus.load_ready !== 1'b1 || bus.load_done !== 1'b0) begin
            errors++;
            $display("FAIL restart_read: valid=%b data=%h err=%b ready=%b done=%b, want 1 %h %b 1 0",
                     bus.weight_valid, bus.weight_data, bus.weight_err, bus.load_ready,
                     bus.load_done, e.data, e.err);
        end
        load_words(0, 200, KEY2);
        drive_req(5, 0, '0, 1'b1);
        @(negedge clk);
        bus.weight_req = 1'b0;
        e = sb.pop_front();
        checks++;
        if (bus.weight_valid !== 1'b1 || bus.weight_data !== e.data || bus.weight_err !== e.err
            || bus.load_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_read: valid=%b data=%h err=%b ready=%b, want 1 %h %b 1",
                     bus.weight_valid, bus.weight_data, bus.weight_err, bus.load_ready, e.data, e.err);
        end
        load_words(200, DEPTH - 201, KEY2);
        checks++;
        if (bus.load_done !== 1'b0) begin
            errors++;
            $display("FAIL reload_one_short: done=%b, want 0", bus.load_done);
        end
        load_words(DEPTH - 1, 1, KEY2);
        checks++;
        if (bus.load_done !== 1'b1) begin
            errors++;
            $display("FAIL reload_done: done=%b, want 1", bus.load_done);
        end
        drive_req(200, 0, WIDTH'(200) ^ KEY2, 1'b1);
        @(negedge clk);
        bus.weight_req = 1'b0;
        e = sb.pop_front();
        checks++;
        if (bus.weight_valid !== 1'b1 || bus.weight_data !== e.data || bus.weight_err !== e.err) begin
            errors++;
            $display("FAIL reload_read: valid=%b data=%h err=%b, want valid=1 data=%h err=%b",
                     bus.weight_valid, bus.weight_data, bus.weight_err, e.data, e.err);
        end
        // Third load: restart at ptr 1000 together with a word that must be dropped.
        bus.load_start = 1'b1;
        @(negedge clk);
        bus.load_start = 1'b0;
        checks++;
        if (bus.weight_err !== 1'b0 || bus.load_ready !== 1'b1) begin
            errors++;
            $display("FAIL err_clear: err=%b ready=%b, want err=0 ready=1", bus.weight_err, bus.load_ready);
        end
        load_words(0, 1000, KEY3);
        bus.load_start = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_data  = 16'hDEAD;
        @(negedge clk);
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        load_words(0, DEPTH - 1, KEY3);
        checks++;
        if (bus.load_done !== 1'b0 || bus.load_ready !== 1'b1) begin
            errors++;
            $display("FAIL restart_one_short: done=%b ready=%b, want done=0 ready=1",
                     bus.load_done, bus.load_ready);
        end
        load_words(DEPTH - 1, 1, KEY3);
        checks++;
        if (bus.load_done !== 1'b1) begin
            errors++;
            $display("FAIL restart_done: done=%b, want 1", bus.load_done);
        end
        drive_req(0, 0, WIDTH'(0) ^ KEY3, 1'b0);
        @(negedge clk);
        drive_req(3790, 8, WIDTH'(3790) ^ KEY3, 1'b0);
        for (int i = 0; i < 2; i++) begin
            if (i == 1) begin
                @(negedge clk);
                bus.weight_req = 1'b0;
            end
            e = sb.pop_front();
            checks++;
            if (bus.weight_valid !== 1'b1 || bus.weight_data !== e.data || bus.weight_err !== e.err) begin
                errors++;
                $display("FAIL restart_read[%0d]: valid=%b data=%h err=%b, want valid=1 data=%h err=%b",
                         i, bus.weight_valid, bus.weight_data, bus.weight_err, e.data, e.err);
            end
        end
    endtask

    task automatic test_rst_mid_load();
        exp_t e;
        bus.load_start = 1'b1;
        @(negedge clk);
        bus.load_start = 1'b0;
        load_words(0, 50, KEY1);
        drive_req(0, 0, '0, 1'b1);
        @(negedge clk);
        bus.weight_req = 1'b0;
        e = sb.pop_front();
        checks++;
        if (bus.weight_valid !== 1'b1 || bus.weight_data !== e.data || bus.weight_err !== e.err) begin
            errors++;
            $display("FAIL pre_rst_read: valid=%b data=%h err=%b, want valid=1 data=%h err=%b",
                     bus.weight_valid, bus.weight_data, bus.weight_err, e.data, e.err);
        end
        rst            = 1'b1;
        bus.load_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.weight_valid !== 1'b0 || bus.weight_data !== '0 || bus.weight_err !== 1'b0
            || bus.load_ready !== 1'b0 || bus.load_done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_load: valid=%b data=%h err=%b ready=%b done=%b, want all 0",
                     bus.weight_valid, bus.weight_data, bus.weight_err, bus.load_ready, bus.load_done);
        end
        repeat (3) @(negedge clk);
        bus.load_valid = 1'b0;
        checks++;
        if (bus.load_ready !== 1'b0 || bus.load_done !== 1'b0) begin
            errors++;
            $display("FAIL empty_ignores_load: ready=%b done=%b, want 0 0", bus.load_ready, bus.load_done);
        end
        drive_req(512, 1, '0, 1'b1);
        @(negedge clk);
        bus.weight_req = 1'b0;
        e = sb.pop_front();
        checks++;
        if (bus.weight_valid !== 1'b1 || bus.weight_data !== e.data || bus.weight_err !== e.err) begin
            errors++;
            $display("FAIL post_rst_read: valid=%b data=%h err=%b, want valid=1 data=%h err=%b",
                     bus.weight_valid, bus.weight_data, bus.weight_err, e.data, e.err);
        end
    endtask

    initial begin
        bus.load_start  = 1'b0;
        bus.load_valid  = 1'b0;
        bus.load_data   = '0;
        bus.weight_req  = 1'b0;
        bus.weight_addr = '0;
        bus.weight_type = '0;
        test_reset();
        test_empty_read();
        test_first_load();
        test_region_read();
        test_back_to_back();
        test_errors();
        test_restart();
        test_rst_mid_load();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d responses outstanding, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
